// File: rtl/wb_bus_pkg.sv
// -----------------------------------------------------------------------------
// wb_bus_pkg
// Shared definitions for the rvj1 Wishbone interconnect.
//   - Wishbone B4 classic width constants
//   - arbiter state encoding
//   - default SoC memory map (IRAM / DRAM / UART windows)
//   - address match helper used by the decoder
// -----------------------------------------------------------------------------
package wb_bus_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } wb_state_e;

    // Default memory map: three 16 KiB windows starting at 0x3000_0000.
    localparam logic [WB_ADR_W-1:0] IRAM_BASE = 32'h3000_0000;
    localparam logic [WB_ADR_W-1:0] IRAM_MASK = 32'hFFFF_C000;
    localparam logic [WB_ADR_W-1:0] DRAM_BASE = 32'h3000_4000;
    localparam logic [WB_ADR_W-1:0] DRAM_MASK = 32'hFFFF_C000;
    localparam logic [WB_ADR_W-1:0] UART_BASE = 32'h3000_8000;
    localparam logic [WB_ADR_W-1:0] UART_MASK = 32'hFFFF_C000;

    // True when adr falls in the window described by base/mask.
    function automatic logic addr_hit(input logic [WB_ADR_W-1:0] adr,
                                      input logic [WB_ADR_W-1:0] base,
                                      input logic [WB_ADR_W-1:0] mask);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin grant selection. Searches the request vector upward starting one
// position above the last granted master, wrapping around.
//   i_clk    clock
//   i_rst    asynchronous active-high reset (last grant -> NUM_MASTERS-1)
//   i_req    request vector (one bit per master)
//   i_load   commit o_grant as the new last grant
//   o_grant  one-hot winner for the current request vector (combinational)
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_load,
    output logic [NUM_MASTERS-1:0] o_grant
);

    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] LAST_RST = ONE << (NUM_MASTERS - 1);

    logic [NUM_MASTERS-1:0] r_last;
    logic [NUM_MASTERS-1:0] w_upto_last;
    logic [NUM_MASTERS-1:0] w_req_hi;
    logic [NUM_MASTERS-1:0] w_pick;

    // r_last is one-hot; (r_last << 1) - 1 sets every bit at or below it.
    // For the top master the shift wraps to 0 and the subtraction yields all ones.
    assign w_upto_last = (r_last << 1) - ONE;
    assign w_req_hi    = i_req & ~w_upto_last;
    // Requests above the last grant win; otherwise wrap to the lowest request.
    assign w_pick      = (|w_req_hi) ? w_req_hi : i_req;
    // Isolate the lowest set bit.
    assign o_grant     = w_pick & (~w_pick + ONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= LAST_RST;
        end else if (i_load && (|o_grant)) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Wishbone B4 classic arbiter + address decoder. Connects NUM_MASTERS masters to
// NUM_SLAVES slaves with round-robin arbitration, bus locking while the granted
// master holds cyc, mask/base decode, and a bus error for unmapped addresses or
// slave timeouts.
//   wb_clk_i / wb_rst_i          clock, asynchronous active-high reset
//   m_cyc_i/stb_i/we_i/sel_i/
//   m_adr_i/dat_i                packed per-master request signals
//   m_ack_o/err_o                per-master responses (granted master only)
//   m_dat_o                      selected slave read data, replicated per master
//   s_cyc_o/stb_o                per-slave cycle/strobe
//   s_we_o/sel_o/adr_o/dat_o     shared slave request signals
//   s_ack_i/dat_i                per-slave responses
//   grant_o                      one-hot current grant (debug)
// Slave k occupies bits [32k+31:32k] of SLAVE_BASE / SLAVE_MASK.
// -----------------------------------------------------------------------------
module wb_bus_arbiter
    import wb_bus_pkg::*;
#(
    parameter int unsigned                 NUM_MASTERS = 3,
    parameter int unsigned                 NUM_SLAVES  = 3,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE  = {UART_BASE, DRAM_BASE, IRAM_BASE},
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK  = {UART_MASK, DRAM_MASK, IRAM_MASK},
    parameter int unsigned                 TIMEOUT     = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,

    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_o,

    output logic [NUM_SLAVES-1:0]           s_cyc_o,
    output logic [NUM_SLAVES-1:0]           s_stb_o,
    output logic                            s_we_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic [NUM_SLAVES-1:0]           s_ack_i,
    input  logic [WB_DAT_W*NUM_SLAVES-1:0]  s_dat_i,

    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    wb_state_e              r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [15:0]            r_cnt;
    logic                   r_err;

    logic [NUM_MASTERS-1:0] w_rr_grant;
    logic                   w_rr_load;

    logic                   w_cyc;
    logic                   w_stb;
    logic                   w_we;
    logic [WB_SEL_W-1:0]    w_sel;
    logic [WB_ADR_W-1:0]    w_adr;
    logic [WB_DAT_W-1:0]    w_dat;

    logic [NUM_SLAVES-1:0]  w_hit;
    logic                   w_any_hit;
    logic                   w_slv_ack;
    logic [WB_DAT_W-1:0]    w_slv_dat;

    logic                   w_busy;
    logic                   w_req_live;
    logic                   w_ack;

    // -------------------------------------------------------------------------
    // Round-robin grant selection
    // -------------------------------------------------------------------------
    assign w_rr_load = (r_state == IDLE) && (|m_cyc_i);

    wb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_req   (m_cyc_i),
        .i_load  (w_rr_load),
        .o_grant (w_rr_grant)
    );

    // -------------------------------------------------------------------------
    // Master mux (AND-OR over the one-hot grant; all zero when nothing granted)
    // -------------------------------------------------------------------------
    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        w_sel = '0;
        w_adr = '0;
        w_dat = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_cyc = m_cyc_i[i];
                w_stb = m_stb_i[i];
                w_we  = m_we_i[i];
                w_sel = m_sel_i[i*WB_SEL_W +: WB_SEL_W];
                w_adr = m_adr_i[i*WB_ADR_W +: WB_ADR_W];
                w_dat = m_dat_i[i*WB_DAT_W +: WB_DAT_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Address decode: lowest matching slave wins
    // -------------------------------------------------------------------------
    always_comb begin
        w_hit     = '0;
        w_any_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (!w_any_hit && addr_hit(w_adr, SLAVE_BASE[k*32 +: 32], SLAVE_MASK[k*32 +: 32])) begin
                w_hit[k]  = 1'b1;
                w_any_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_slv_ack = 1'b0;
        w_slv_dat = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (w_hit[k]) begin
                w_slv_ack = s_ack_i[k];
                w_slv_dat = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slave-side and master-side outputs
    // -------------------------------------------------------------------------
    assign w_busy     = (r_state == BUSY);
    assign w_req_live = w_busy && w_cyc;
    assign w_ack      = w_req_live && w_stb && w_slv_ack;

    assign s_cyc_o = w_req_live           ? w_hit : '0;
    assign s_stb_o = (w_req_live && w_stb) ? w_hit : '0;
    assign s_we_o  = w_we;
    assign s_sel_o = w_sel;
    assign s_adr_o = w_adr;
    assign s_dat_o = w_dat;

    assign m_ack_o = w_ack ? r_grant : '0;
    assign m_err_o = r_err ? r_grant : '0;
    assign m_dat_o = {NUM_MASTERS{w_busy ? w_slv_dat : {WB_DAT_W{1'b0}}}};
    assign grant_o = r_grant;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (|m_cyc_i) begin
                        r_grant <= w_rr_grant;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_cyc) begin
                        // Lock released.
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end else if (!w_stb || w_ack) begin
                        // An ack on the timeout cycle still wins.
                        r_cnt <= '0;
                    end else if (!w_any_hit) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_M1) begin
                        // TIMEOUT strobe cycles without ack: error on the next one.
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ERR: begin
                    if (w_cyc) begin
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [11:0] m_sel;
    logic [95:0] m_adr, m_dat;
    logic [2:0]  m_ack, m_err;
    logic [95:0] m_rdat;
    logic [2:0]  s_cyc, s_stb;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [2:0]  s_ack;
    logic [95:0] s_dat;
    logic [2:0]  grant;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .NUM_MASTERS (3),
        .NUM_SLAVES  (3),
        .TIMEOUT     (4)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .m_dat_o  (m_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_dat),
        .grant_o  (grant)
    );

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[i]          = cyc;
        m_stb[i]          = stb;
        m_we[i]           = we;
        m_sel[i*4 +: 4]   = sel;
        m_adr[i*32 +: 32] = adr;
        m_dat[i*32 +: 32] = dat;
    endtask

    task automatic clear_all();
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = '0; s_dat = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        repeat (2) @(negedge clk);
        n_total++;
        if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant);
        else n_pass++;
        n_total++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 12'h000)
            $display("FAIL reset_outs: got %h want 000", {s_cyc, s_stb, m_ack, m_err});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_priority();
        @(negedge clk);
        set_m(0, 1, 1, 0, 4'hF, 32'h3000_0010, 32'h0);
        set_m(1, 1, 0, 0, 4'hF, 32'h3000_4000, 32'h0);
        #1;
        n_total++;
        if (grant !== 3'b000) $display("FAIL prio_latency: got %b want 000", grant);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b001) $display("FAIL prio_grant0: got %b want 001", grant);
        else n_pass++;
        n_total++;
        if (s_stb !== 3'b001 || s_adr !== 32'h3000_0010)
            $display("FAIL prio_route: got stb=%b adr=%h want 001 30000010", s_stb, s_adr);
        else n_pass++;
        @(negedge clk);
        s_ack = 3'b001;
        s_dat[31:0] = 32'hDEAD_BEEF;
        #1;
        n_total++;
        if (m_ack !== 3'b001) $display("FAIL prio_ack: got %b want 001", m_ack);
        else n_pass++;
        n_total++;
        if (m_rdat !== {3{32'hDEAD_BEEF}})
            $display("FAIL prio_rdata: got %h want %h", m_rdat, {3{32'hDEAD_BEEF}});
        else n_pass++;
        @(negedge clk);
        s_ack = 3'b000;
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        n_total++;
        if (s_cyc !== 3'b000) $display("FAIL prio_cyc_drop: got %b want 000", s_cyc);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b000) $display("FAIL prio_idle_gap: got %b want 000", grant);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b010) $display("FAIL prio_rotate: got %b want 010", grant);
        else n_pass++;
        n_total++;
        if (s_cyc !== 3'b010 || s_stb !== 3'b000)
            $display("FAIL prio_m1_cyc: got cyc=%b stb=%b want 010 000", s_cyc, s_stb);
        else n_pass++;
        clear_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_decode();
        @(negedge clk);
        set_m(2, 1, 1, 1, 4'b0011, 32'h3000_8004, 32'hA5A5_0001);
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b100) $display("FAIL dec_grant: got %b want 100", grant);
        else n_pass++;
        n_total++;
        if (s_stb !== 3'b100 || s_cyc !== 3'b100)
            $display("FAIL dec_stb: got stb=%b cyc=%b want 100 100", s_stb, s_cyc);
        else n_pass++;
        n_total++;
        if (s_sel !== 4'b0011 || s_wdat !== 32'hA5A5_0001)
            $display("FAIL dec_wdata: got sel=%b dat=%h want 0011 a5a50001", s_sel, s_wdat);
        else n_pass++;
        n_total++;
        if (s_we !== 1'b1 || s_adr !== 32'h3000_8004)
            $display("FAIL dec_we_adr: got we=%b adr=%h want 1 30008004", s_we, s_adr);
        else n_pass++;
        @(negedge clk);
        s_ack = 3'b100;
        #1;
        n_total++;
        if (m_ack !== 3'b100) $display("FAIL dec_ack: got %b want 100", m_ack);
        else n_pass++;
        @(negedge clk);
        clear_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        set_m(1, 1, 1, 0, 4'hF, 32'h4000_0000, 32'h0);
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b010 || s_stb !== 3'b000 || m_err !== 3'b000)
            $display("FAIL unm_decode: got grant=%b stb=%b err=%b want 010 000 000",
                     grant, s_stb, m_err);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_err !== 3'b010 || m_ack !== 3'b000)
            $display("FAIL unm_err: got err=%b ack=%b want 010 000", m_err, m_ack);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_err !== 3'b000) $display("FAIL unm_err_once: got %b want 000", m_err);
        else n_pass++;
        clear_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        set_m(0, 1, 1, 0, 4'hF, 32'h3000_4000, 32'h0);
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            n_total++;
            if (s_stb !== 3'b010 || m_err !== 3'b000)
                $display("FAIL to_wait%0d: got stb=%b err=%b want 010 000", c, s_stb, m_err);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (s_stb !== 3'b000 || m_err !== 3'b001)
            $display("FAIL to_err: got stb=%b err=%b want 000 001", s_stb, m_err);
        else n_pass++;
        clear_all();
        repeat (2) @(posedge clk);
        // Repeat with the ack landing on the 4th strobe cycle.
        @(negedge clk);
        set_m(0, 1, 1, 0, 4'hF, 32'h3000_4000, 32'h0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        s_ack = 3'b010;
        #1;
        n_total++;
        if (m_ack !== 3'b001 || m_err !== 3'b000)
            $display("FAIL to_ack_wins: got ack=%b err=%b want 001 000", m_ack, m_err);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_err !== 3'b000) $display("FAIL to_no_err: got %b want 000", m_err);
        else n_pass++;
        clear_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_lock();
        @(negedge clk);
        set_m(0, 1, 1, 0, 4'hF, 32'h3000_0000, 32'h0);
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b001 || s_stb !== 3'b001)
            $display("FAIL rl_pre: got grant=%b stb=%b want 001 001", grant, s_stb);
        else n_pass++;
        @(negedge clk);
        set_m(1, 1, 0, 0, 4'hF, 32'h3000_4000, 32'h0);
        s_ack = 3'b001;
        rst = 1'b1;
        #1;
        n_total++;
        if (grant !== 3'b000) $display("FAIL rl_rst_grant: got %b want 000", grant);
        else n_pass++;
        n_total++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 12'h000)
            $display("FAIL rl_rst_outs: got %h want 000", {s_cyc, s_stb, m_ack, m_err});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        s_ack = 3'b000;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b001) $display("FAIL rl_prio: got %b want 001", grant);
        else n_pass++;
        s_ack = 3'b001;
        for (int b = 0; b < 3; b++) begin
            #1;
            n_total++;
            if (m_ack !== 3'b001 || grant !== 3'b001)
                $display("FAIL rl_beat%0d: got ack=%b grant=%b want 001 001", b, m_ack, grant);
            else n_pass++;
            @(posedge clk); #1;
        end
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        s_ack = 3'b000;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b000) $display("FAIL rl_release: got %b want 000", grant);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (grant !== 3'b010) $display("FAIL rl_pending: got %b want 010", grant);
        else n_pass++;
        clear_all();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_decode();
        test_unmapped();
        test_timeout();
        test_reset_lock();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
